// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle control sequencer for the RISC-V datapath.
// Each instruction is stepped through IF, ID, EX, optional EX wait, MEM,
// WB, optional WB wait and SUMPC. A halt word decoded in ID parks the
// sequencer in FIM until a start pulse arrives.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   start       restart pulse, honoured only in FIM
//   instrucao   fetched instruction, valid from ID onward
//   mem_access  current instruction is a load/store (sampled in ID)
//   mem_ready   data memory completes the access this cycle
//   estado      current state code
//   fetch_en .. pc_en, halted   one-hot Moore strobes decoded from estado
//   erro        sticky memory-timeout flag (cleared by start in FIM)
//   instret     retired-instruction counter
module sequenciador_multiciclo #(
  parameter int unsigned            XLEN        = 32,
  parameter int unsigned            EX_WAIT     = 2,
  parameter int unsigned            WB_WAIT     = 2,
  parameter int unsigned            SKIP_MEM    = 0,
  parameter int unsigned            MEM_TIMEOUT = 8,
  parameter logic [XLEN-1:0]        HALT_WORD   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] instrucao,
  input  logic            mem_access,
  input  logic            mem_ready,
  output logic [3:0]      estado,
  output logic            fetch_en,
  output logic            decode_en,
  output logic            exec_en,
  output logic            mem_en,
  output logic            wb_en,
  output logic            pc_en,
  output logic            halted,
  output logic            erro,
  output logic [31:0]     instret
);

  localparam logic [3:0] S_IF    = 4'b0000;
  localparam logic [3:0] S_ID    = 4'b0001;
  localparam logic [3:0] S_EX    = 4'b0010;
  localparam logic [3:0] S_MEM   = 4'b0011;
  localparam logic [3:0] S_WB    = 4'b0100;
  localparam logic [3:0] S_EXW   = 4'b0101;
  localparam logic [3:0] S_WBW   = 4'b0110;
  localparam logic [3:0] S_SUMPC = 4'b1000;
  localparam logic [3:0] S_FIM   = 4'b1001;

  // Last count value of each wait/timeout window (counters start at 0 on entry).
  localparam logic [3:0] EX_LAST  = 4'(EX_WAIT - 1);
  localparam logic [3:0] WB_LAST  = 4'(WB_WAIT - 1);
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0]  estado_q,   estado_d;
  logic [3:0]  wait_q,     wait_d;
  logic [7:0]  tmo_q,      tmo_d;
  logic        mem_flag_q, mem_flag_d;
  logic        erro_q,     erro_d;
  logic [31:0] instret_q,  instret_d;

  logic [3:0]  after_ex;

  // Non-memory instructions bypass MEM only when SKIP_MEM is enabled.
  assign after_ex = ((SKIP_MEM != 0) && !mem_flag_q) ? S_WB : S_MEM;

  always_comb begin
    estado_d   = estado_q;
    wait_d     = wait_q;
    tmo_d      = tmo_q;
    mem_flag_d = mem_flag_q;
    erro_d     = erro_q;
    instret_d  = instret_q;

    case (estado_q)
      S_IF: estado_d = S_ID;

      S_ID: begin
        mem_flag_d = mem_access;
        estado_d   = (instrucao == HALT_WORD) ? S_FIM : S_EX;
      end

      S_EX: begin
        if (EX_WAIT > 0) begin
          estado_d = S_EXW;
          wait_d   = '0;
        end else begin
          estado_d = after_ex;
          tmo_d    = '0;
        end
      end

      S_EXW: begin
        if (wait_q == EX_LAST) begin
          estado_d = after_ex;
          tmo_d    = '0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      S_MEM: begin
        tmo_d = tmo_q + 8'd1;
        // A ready in the expiry cycle still completes the access.
        if (!mem_flag_q || mem_ready) begin
          estado_d = S_WB;
        end else if (tmo_q == TMO_LAST) begin
          estado_d = S_FIM;
          erro_d   = 1'b1;
        end
      end

      S_WB: begin
        if (WB_WAIT > 0) begin
          estado_d = S_WBW;
          wait_d   = '0;
        end else begin
          estado_d = S_SUMPC;
        end
      end

      S_WBW: begin
        if (wait_q == WB_LAST) begin
          estado_d = S_SUMPC;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      S_SUMPC: begin
        estado_d  = S_IF;
        instret_d = instret_q + 32'd1;
      end

      S_FIM: begin
        if (start) begin
          estado_d = S_IF;
          erro_d   = 1'b0;
        end
      end

      default: estado_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_q   <= S_IF;
      wait_q     <= '0;
      tmo_q      <= '0;
      mem_flag_q <= 1'b0;
      erro_q     <= 1'b0;
      instret_q  <= '0;
    end else begin
      estado_q   <= estado_d;
      wait_q     <= wait_d;
      tmo_q      <= tmo_d;
      mem_flag_q <= mem_flag_d;
      erro_q     <= erro_d;
      instret_q  <= instret_d;
    end
  end

  assign estado    = estado_q;
  assign fetch_en  = (estado_q == S_IF);
  assign decode_en = (estado_q == S_ID);
  assign exec_en   = (estado_q == S_EX);
  assign mem_en    = (estado_q == S_MEM);
  assign wb_en     = (estado_q == S_WB);
  assign pc_en     = (estado_q == S_SUMPC);
  assign halted    = (estado_q == S_FIM);
  assign erro      = erro_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed bench for sequenciador_multiciclo. Four instances with different
// parameter sets share one stimulus; each phase checks the instance(s) whose
// parameters the scenario targets.
//   u0: defaults   u1: SKIP_MEM=1   u2: MEM_TIMEOUT=4   u3: EX_WAIT=0, WB_WAIT=0
module tb_sequenciador_multiciclo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instrucao = 32'h0050_0093;
  logic        mem_access = 1'b0;
  logic        mem_ready = 1'b1;

  logic [3:0][3:0]  estado_w;
  logic [3:0]       fetch_w, decode_w, exec_w, mem_w, wb_w, pc_w, halted_w, erro_w;
  logic [3:0][31:0] instret_w;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  sequenciador_multiciclo u0 (
    .clk(clk), .rst(rst), .start(start), .instrucao(instrucao),
    .mem_access(mem_access), .mem_ready(mem_ready), .estado(estado_w[0]),
    .fetch_en(fetch_w[0]), .decode_en(decode_w[0]), .exec_en(exec_w[0]),
    .mem_en(mem_w[0]), .wb_en(wb_w[0]), .pc_en(pc_w[0]), .halted(halted_w[0]),
    .erro(erro_w[0]), .instret(instret_w[0])
  );

  sequenciador_multiciclo #(.SKIP_MEM(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .instrucao(instrucao),
    .mem_access(mem_access), .mem_ready(mem_ready), .estado(estado_w[1]),
    .fetch_en(fetch_w[1]), .decode_en(decode_w[1]), .exec_en(exec_w[1]),
    .mem_en(mem_w[1]), .wb_en(wb_w[1]), .pc_en(pc_w[1]), .halted(halted_w[1]),
    .erro(erro_w[1]), .instret(instret_w[1])
  );

  sequenciador_multiciclo #(.MEM_TIMEOUT(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .instrucao(instrucao),
    .mem_access(mem_access), .mem_ready(mem_ready), .estado(estado_w[2]),
    .fetch_en(fetch_w[2]), .decode_en(decode_w[2]), .exec_en(exec_w[2]),
    .mem_en(mem_w[2]), .wb_en(wb_w[2]), .pc_en(pc_w[2]), .halted(halted_w[2]),
    .erro(erro_w[2]), .instret(instret_w[2])
  );

  sequenciador_multiciclo #(.EX_WAIT(0), .WB_WAIT(0)) u3 (
    .clk(clk), .rst(rst), .start(start), .instrucao(instrucao),
    .mem_access(mem_access), .mem_ready(mem_ready), .estado(estado_w[3]),
    .fetch_en(fetch_w[3]), .decode_en(decode_w[3]), .exec_en(exec_w[3]),
    .mem_en(mem_w[3]), .wb_en(wb_w[3]), .pc_en(pc_w[3]), .halted(halted_w[3]),
    .erro(erro_w[3]), .instret(instret_w[3])
  );

  // Expected {fetch, decode, exec, mem, wb, pc, halted} for a state code.
  function automatic logic [6:0] exp_strobes(input logic [3:0] code);
    case (code)
      4'b0000: return 7'b1000000;
      4'b0001: return 7'b0100000;
      4'b0010: return 7'b0010000;
      4'b0011: return 7'b0001000;
      4'b0100: return 7'b0000100;
      4'b1000: return 7'b0000010;
      4'b1001: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input int d, input logic [3:0] expv, input string tag);
    logic [6:0] strb;
    strb = {fetch_w[d], decode_w[d], exec_w[d], mem_w[d], wb_w[d], pc_w[d], halted_w[d]};
    chk($sformatf("%s_estado_u%0d", tag, d), {28'd0, estado_w[d]}, {28'd0, expv});
    chk($sformatf("%s_strobes_u%0d", tag, d), {25'd0, strb}, {25'd0, exp_strobes(expv)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [3:0] seq_a [11] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h5, 4'h3, 4'h4, 4'h6, 4'h6, 4'h8, 4'h0};
  logic [3:0] seq_b [10] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h5, 4'h4, 4'h6, 4'h6, 4'h8, 4'h0};
  logic [3:0] seq_d [7]  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h0};
  logic [3:0] seq_m [14] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h5, 4'h3, 4'h3, 4'h3, 4'h3,
                             4'h4, 4'h6, 4'h6, 4'h8, 4'h0};

  initial begin
    // Reset state; start held high throughout the first instruction to show it is ignored.
    start      = 1'b1;
    instrucao  = 32'h0050_0093;
    mem_access = 1'b0;
    mem_ready  = 1'b1;
    do_reset();
    chk_state(0, 4'h0, "reset");
    chk("reset_erro", {31'd0, erro_w[0]}, 32'd0);
    chk("reset_instret", instret_w[0], 32'd0);

    // Default 10-cycle, skip-mem 9-cycle and no-wait 6-cycle instructions.
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_state(0, seq_a[k], $sformatf("dflt_k%0d", k));
      if (k <= 9) begin
        chk_state(1, seq_b[k], $sformatf("skip_k%0d", k));
        chk($sformatf("skip_mem_en_k%0d", k), {31'd0, mem_w[1]}, 32'd0);
      end
      if (k <= 6) chk_state(3, seq_d[k], $sformatf("nowait_k%0d", k));
    end
    chk("dflt_instret", instret_w[0], 32'd1);
    chk("skip_instret", instret_w[1], 32'd1);
    chk("nowait_instret", instret_w[3], 32'd1);
    start = 1'b0;

    // Memory instruction, ready arrives in the 4th MEM cycle; for u2 that is
    // also its timeout cycle, where ready must win.
    do_reset();
    mem_access = 1'b1;
    mem_ready  = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk_state(0, seq_m[k], $sformatf("memwait_k%0d", k));
      chk_state(2, seq_m[k], $sformatf("tmo_edge_k%0d", k));
      if (k == 8) mem_ready = 1'b1;
    end
    chk("memwait_erro", {31'd0, erro_w[0]}, 32'd0);
    chk("tmo_edge_erro", {31'd0, erro_w[2]}, 32'd0);
    chk("memwait_instret", instret_w[0], 32'd1);

    // Halt word: FIM with instret preserved, start low keeps it there.
    instrucao  = 32'd0;
    mem_access = 1'b0;
    tick();
    chk_state(0, 4'h1, "halt_id");
    tick();
    chk_state(0, 4'h9, "halt_fim");
    chk("halt_instret", instret_w[0], 32'd1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("halt_hold_%0d", k), {28'd0, estado_w[0]}, 32'h9);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state(0, 4'h0, "halt_restart");
    chk("halt_restart_instret", instret_w[0], 32'd1);

    // Timeout: MEM_TIMEOUT=4 with no ready ever -> 4 MEM cycles, then FIM with erro.
    instrucao  = 32'h0050_0093;
    mem_access = 1'b1;
    mem_ready  = 1'b0;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_state(2, seq_m[k], $sformatf("tmo_k%0d", k));
    end
    tick();
    chk_state(2, 4'h9, "tmo_fim");
    chk("tmo_erro", {31'd0, erro_w[2]}, 32'd1);
    tick();
    chk_state(2, 4'h9, "tmo_hold");
    chk("tmo_erro_sticky", {31'd0, erro_w[2]}, 32'd1);
    chk("tmo_instret", instret_w[2], 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state(2, 4'h0, "tmo_restart");
    chk("tmo_erro_clr", {31'd0, erro_w[2]}, 32'd0);

    // Reset while in WBW abandons the instruction.
    mem_access = 1'b0;
    mem_ready  = 1'b1;
    do_reset();
    for (int k = 1; k <= 7; k++) tick();
    chk_state(0, 4'h6, "midrst_wbw");
    rst = 1'b0;
    tick();
    chk_state(0, 4'h0, "midrst_if");
    chk("midrst_instret", instret_w[0], 32'd0);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
